// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bursts and occupancy throttling.
// Optional macro STALL_CNT_EN enables the saturating stall statistics counter on stall_cnt.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 10,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [CNT_W-1:0]          fifo_count,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [15:0]               stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'((2**CNT_W) - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [3:0]         r_beat_cnt, w_beat_cnt_nxt;
  logic               r_fifo_we, w_fifo_we_nxt;
  logic [DATA_W-1:0]  r_fifo_din, w_fifo_din_nxt;

  logic [CNT_W:0]     w_level;
  logic               w_space_ok;
  logic               w_req_g, w_ack_g, w_burst_end;
  logic [IDX_W-1:0]   w_owner_inc, w_arb_base, w_arb_idx;
  logic               w_arb_found;
  logic [DATA_W-1:0]  w_data_g;

  // The write already registered but not yet reflected in fifo_count is counted as occupied.
  assign w_level    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, r_fifo_we};
  assign w_space_ok = !fifo_full && (w_level < LIMIT);

  assign w_req_g     = req[r_owner];
  assign w_data_g    = data[int'(r_owner)*DATA_W +: DATA_W];
  assign w_ack_g     = (r_state == OWN) && w_req_g && w_space_ok && !reset;
  assign w_burst_end = (r_state == OWN) &&
                       (!w_req_g || (w_ack_g && r_beat_cnt == 4'(BURST_LEN - 1)));

  assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  // At burst end the search starts just past the departing owner, matching the pointer update.
  assign w_arb_base  = (r_state == OWN) ? w_owner_inc : r_rr_ptr;

  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    v_idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = IDX_W'((int'(w_arb_base) + k) % NUM_REQ);
      if (req[v_idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = v_idx;
      end
    end
  end

  always_comb begin
    ack          = '0;
    ack[r_owner] = w_ack_g;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_fifo_we_nxt  = 1'b0;
    w_fifo_din_nxt = r_fifo_din;
    case (r_state)
      IDLE: begin
        if (w_arb_found) begin
          w_state_nxt    = OWN;
          w_owner_nxt    = w_arb_idx;
          w_grant_nxt    = NUM_REQ'(1) << w_arb_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      OWN: begin
        if (w_ack_g) begin
          w_fifo_we_nxt  = 1'b1;
          w_fifo_din_nxt = w_data_g;
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
        end
        if (w_burst_end) begin
          w_rr_ptr_nxt   = w_owner_inc;
          w_beat_cnt_nxt = '0;
          if (w_arb_found) begin
            w_owner_nxt = w_arb_idx;
            w_grant_nxt = NUM_REQ'(1) << w_arb_idx;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_fifo_we  <= 1'b0;
      r_fifo_din <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_fifo_we  <= w_fifo_we_nxt;
      r_fifo_din <= w_fifo_din_nxt;
    end
  end

  assign grant    = r_grant;
  assign fifo_we  = r_fifo_we;
  assign fifo_din = r_fifo_din;

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (r_state == OWN && w_req_g && !w_space_ok && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: scoreboard of expected FIFO words, FIFO occupancy model,
// per-cycle invariants (one-hot grant, ack only to owner, count limit, stall statistics).
module tb_fifo_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        grant;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_we;
  logic [DATA_W-1:0]         fifo_din;
  logic [15:0]               stall_cnt;

  fifo_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BURST_LEN(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .grant     (grant),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester models: each presents base+nxt while remaining > 0 and advances on ack.
  int          remaining [NUM_REQ];
  logic [7:0]  base      [NUM_REQ];
  logic [7:0]  nxt       [NUM_REQ];
  int          level;
  bit          drain;
  logic [7:0]  exp_q [$];

  logic [NUM_REQ-1:0] s_ack, s_grant;
  logic               s_we;
  logic [7:0]         s_din;
  int                 stall_exp;
  int                 cyc;
  int                 first_wr, last_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]                = (remaining[i] > 0);
      data[i*DATA_W +: DATA_W] = base[i] + nxt[i];
    end
    fifo_count = CNT_W'(level);
    fifo_full  = (level >= 15);
  endtask

  // One clock cycle: sample and check at negedge, then apply FIFO and requester updates after posedge.
  task automatic tick();
    bit rst_s;
    @(negedge clk);
    s_ack   = ack;
    s_grant = grant;
    s_we    = fifo_we;
    s_din   = fifo_din;
    rst_s   = reset;
    check("grant_onehot0", 32'($onehot0(s_grant)), 32'd1);
    check("ack_only_owner", 32'(s_ack & ~s_grant), 32'd0);
    check("count_limit", 32'(level <= 15), 32'd1);
`ifdef STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
`else
    check("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif
    if (rst_s)
      stall_exp = 0;
    else if ((req & s_grant) != 0 && (s_ack & s_grant) == 0)
      stall_exp++;
    if (s_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(s_din), 32'hFFFF_FFFF);
      end else begin
        check("fifo_din", 32'(s_din), 32'(exp_q.pop_front()));
      end
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
    level = level + (s_we ? 1 : 0) - ((drain && level > 0) ? 1 : 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_ack[i]) begin
        nxt[i]++;
        remaining[i]--;
      end
    end
    drive_inputs();
  endtask

  initial begin
    int guard;
    int ack_cnt;
    stall_exp = 0;
    cyc       = 0;
    first_wr  = -1;
    last_wr   = -1;
    level     = 0;
    drain     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = 1;
      base[i]      = 8'h00;
      nxt[i]       = 8'h00;
    end
    reset = 1'b1;
    drive_inputs();

    // Reset held three cycles with every requester asking.
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rst_grant", 32'(s_grant), 32'd0);
      check("rst_we", 32'(s_we), 32'd0);
      check("rst_ack", 32'(s_ack), 32'd0);
    end

    // Round robin: requester 0 has two bursts' worth, others one each.
    remaining[0] = 8;
    remaining[1] = 4;
    remaining[2] = 4;
    remaining[3] = 4;
    for (int i = 0; i < NUM_REQ; i++) begin
      base[i] = 8'(8'h10 * i);
      nxt[i]  = 8'h00;
    end
    for (int i = 0; i < NUM_REQ; i++)
      for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'h10 * i + n));
    for (int n = 4; n < 8; n++) exp_q.push_back(8'(n));
    drain    = 1'b1;
    first_wr = -1;
    reset    = 1'b0;
    drive_inputs();
    guard = 0;
    while (exp_q.size() > 0 && guard < 80) begin
      tick();
      guard++;
    end
    check("rr_all_written", 32'(exp_q.size()), 32'd0);
    check("rr_throughput", 32'(last_wr - first_wr), 32'd19);
    for (int n = 0; n < 3; n++) tick();
    check("rr_idle_grant", 32'(s_grant), 32'd0);

    // Single word from requester 2 into an empty FIFO with no reads.
    drain        = 1'b0;
    remaining[2] = 1;
    base[2]      = 8'hA5;
    nxt[2]       = 8'h00;
    exp_q.push_back(8'hA5);
    drive_inputs();
    tick();
    check("single_latency_grant", 32'(s_grant), 32'd0);
    check("single_latency_ack", 32'(s_ack), 32'd0);
    tick();
    check("single_grant", 32'(s_grant), 32'b0100);
    check("single_ack", 32'(s_ack), 32'b0100);
    tick();
    check("single_we", 32'(s_we), 32'd1);
    check("single_din", 32'(s_din), 32'hA5);
    tick();
    check("single_release", 32'(s_grant), 32'd0);
    check("single_we_off", 32'(s_we), 32'd0);
    check("single_level", 32'(level), 32'd1);

    // Near-full FIFO: exactly one more word accepted, then stall with grant held.
    level        = 14;
    remaining[0] = 10;
    base[0]      = 8'hC0;
    nxt[0]       = 8'h00;
    exp_q.push_back(8'hC0);
    drive_inputs();
    ack_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (s_ack[0]) ack_cnt++;
    end
    check("full_ack_count", 32'(ack_cnt), 32'd1);
    check("full_level", 32'(level), 32'd15);
    check("full_grant_held", 32'(s_grant), 32'b0001);
    check("full_written", 32'(exp_q.size()), 32'd0);
    remaining[0] = 0;
    level        = 0;
    drive_inputs();
    tick();
    tick();

    // Withdraw mid-burst by requester 1, then reset while requester 3 owns the port.
    drain        = 1'b1;
    remaining[1] = 10;
    remaining[3] = 10;
    base[1]      = 8'h50;
    base[3]      = 8'h70;
    nxt[1]       = 8'h00;
    nxt[3]       = 8'h00;
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    drive_inputs();
    tick();
    tick();
    check("wd_ack1", 32'(s_ack), 32'b0010);
    tick();
    remaining[1] = 0;
    drive_inputs();
    tick();
    check("wd_no_ack", 32'(s_ack), 32'd0);
    check("wd_grant_still1", 32'(s_grant), 32'b0010);
    tick();
    check("wd_grant_moved", 32'(s_grant), 32'b1000);
    check("wd_no_write", 32'(s_we), 32'd0);
    check("wd_ack3", 32'(s_ack), 32'b1000);
    tick();
    reset = 1'b1;
    drive_inputs();
    tick();
    check("rst_own_ack", 32'(s_ack), 32'd0);
    reset = 1'b0;
    drive_inputs();
    tick();
    check("rst_own_grant", 32'(s_grant), 32'd0);
    check("rst_own_we", 32'(s_we), 32'd0);
    remaining[3] = 0;
    drive_inputs();
    for (int n = 0; n < 3; n++) tick();
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(s_grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
